stack_controller: RTL and testbench

- Sequences all push and pop traffic to the stack segment of Data Memory.
- Owns the stack-pointer register internally and drives the memory address, write-enable and read-enable for stack accesses.
- Performs full/empty checks, returns popped data, and reports overflow/underflow.
- Sits between the main control unit (request/done handshake) and the Data Memory port used for stack accesses.

---
 rtl/stack_controller_if.sv | 35 +++
 rtl/stack_controller.sv | 116 +++++++++++
 tb/tb_stack_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stack_controller_if.sv
// Handshake and Data Memory port bundle for the stack controller.
// slave = controller side, master = control unit / memory side.
interface stack_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              push_req;
  logic              pop_req;
  logic [DATA_W-1:0] push_data;
  logic              clr_err;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] top;
  logic              busy;
  logic              done;
  logic              err;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  push_req, pop_req, push_data, clr_err, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, pop_data, top,
           busy, done, err, overflow, underflow
  );

  modport master (
    output push_req, pop_req, push_data, clr_err, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, pop_data, top,
           busy, done, err, overflow, underflow
  );
endinterface

// File: rtl/stack_controller.sv
// Push/pop sequencer for the Data Memory stack segment; owns the stack pointer.
// Every output is a register written on the transition into the state that shows it.
module stack_controller #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int STACK_BASE  = 256,
  parameter int STACK_LIMIT = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  stack_controller_if.slave    bus
);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(STACK_LIMIT);

  typedef enum logic [2:0] {IDLE, PUSH_WR, POP_RD, POP_WAIT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] top_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] pop_q;
  logic              we_q, re_q, busy_q, done_q, err_q, ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      top_q   <= BASE;
      addr_q  <= '0;
      wdata_q <= '0;
      pop_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Clear first so a same-cycle set event below overrides it.
      if (bus.clr_err) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.push_req) begin
            busy_q <= 1'b1;
            if (top_q >= LIMIT) begin
              ovf_q  <= 1'b1;
              done_q <= 1'b1;
              err_q  <= 1'b1;
              state  <= DONE;
            end else begin
              addr_q  <= top_q;
              wdata_q <= bus.push_data;
              we_q    <= 1'b1;
              state   <= PUSH_WR;
            end
          end else if (bus.pop_req) begin
            busy_q <= 1'b1;
            if (top_q <= BASE) begin
              unf_q  <= 1'b1;
              done_q <= 1'b1;
              err_q  <= 1'b1;
              state  <= DONE;
            end else begin
              addr_q <= top_q - 1'b1;
              re_q   <= 1'b1;
              state  <= POP_RD;
            end
          end
        end
        PUSH_WR: begin
          top_q  <= top_q + 1'b1;
          done_q <= 1'b1;
          state  <= DONE;
        end
        POP_RD: begin
          top_q <= top_q - 1'b1;
          state <= POP_WAIT;
        end
        POP_WAIT: begin
          // Memory read data lands one cycle after the read strobe.
          pop_q  <= bus.mem_rdata;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_re    = re_q;
  assign bus.pop_data  = pop_q;
  assign bus.top       = top_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a small synchronous data memory model.
module tb_stack_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_controller_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  stack_controller #(
    .DATA_W(32), .ADDR_W(32), .STACK_BASE(256), .STACK_LIMIT(512)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  int we_cnt = 0;
  int re_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (bus.mem_re) begin
      bus.mem_rdata <= mem[bus.mem_addr[9:0]];
      re_cnt <= re_cnt + 1;
    end
  end

  int total  = 0;
  int passes = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_chk(input logic [31:0] data, input logic [31:0] addr);
    bus.push_req = 1'b1; bus.push_data = data;
    tick();
    bus.push_req = 1'b0; bus.push_data = '0;
    chk("push_we", bus.mem_we, 1);
    chk("push_re", bus.mem_re, 0);
    chk("push_addr", bus.mem_addr, addr);
    chk("push_wdata", bus.mem_wdata, data);
    chk("push_busy", bus.busy, 1);
    chk("push_early_done", bus.done, 0);
    tick();
    chk("push_done", bus.done, 1);
    chk("push_err", bus.err, 0);
    chk("push_we_off", bus.mem_we, 0);
    chk("push_top", bus.top, addr + 1);
    tick();
    chk("push_idle_done", bus.done, 0);
    chk("push_idle_busy", bus.busy, 0);
  endtask

  task automatic pop_chk(input logic [31:0] addr, input logic [31:0] data);
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    chk("pop_re", bus.mem_re, 1);
    chk("pop_we", bus.mem_we, 0);
    chk("pop_addr", bus.mem_addr, addr);
    chk("pop_rd_done", bus.done, 0);
    tick();
    chk("pop_wait_re", bus.mem_re, 0);
    chk("pop_wait_done", bus.done, 0);
    chk("pop_wait_top", bus.top, addr);
    tick();
    chk("pop_done", bus.done, 1);
    chk("pop_err", bus.err, 0);
    chk("pop_data", bus.pop_data, data);
    tick();
    chk("pop_idle_busy", bus.busy, 0);
  endtask

  task automatic push_q(input logic [31:0] data);
    bus.push_req = 1'b1; bus.push_data = data;
    tick();
    bus.push_req = 1'b0;
    tick(); tick();
  endtask

  task automatic pop_q();
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    tick(); tick(); tick();
  endtask

  int we0, re0;

  initial begin
    reset = 1'b1;
    bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = '0; bus.clr_err = 1'b0;
    bus.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_top", bus.top, 256);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_pop_data", bus.pop_data, 0);

    push_chk(32'hDEADBEEF, 256);
    push_chk(32'h12345678, 257);
    chk("top_258", bus.top, 258);
    chk("mem_256", mem[256], 32'hDEADBEEF);
    chk("mem_257", mem[257], 32'h12345678);

    pop_chk(257, 32'h12345678);
    pop_chk(256, 32'hDEADBEEF);
    chk("top_256", bus.top, 256);

    // Underflow, with clr_err in the same cycle: the set must win.
    re0 = re_cnt;
    bus.pop_req = 1'b1; bus.clr_err = 1'b1;
    tick();
    bus.pop_req = 1'b0; bus.clr_err = 1'b0;
    chk("unf_done", bus.done, 1);
    chk("unf_err", bus.err, 1);
    chk("unf_flag", bus.underflow, 1);
    chk("unf_re", bus.mem_re, 0);
    chk("unf_top", bus.top, 256);
    chk("unf_busy", bus.busy, 1);
    tick();
    chk("unf_done_off", bus.done, 0);
    chk("unf_err_off", bus.err, 0);
    chk("unf_busy_off", bus.busy, 0);
    chk("unf_sticky", bus.underflow, 1);
    chk("unf_no_read", re_cnt, re0);
    chk("unf_pop_data", bus.pop_data, 32'hDEADBEEF);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("unf_cleared", bus.underflow, 0);

    for (int i = 0; i < 256; i++) push_q(i);
    chk("full_top", bus.top, 512);
    chk("full_ovf0", bus.overflow, 0);
    chk("full_mem_300", mem[300], 44);
    we0 = we_cnt;
    bus.push_req = 1'b1; bus.push_data = 32'h00000BAD;
    tick();
    bus.push_req = 1'b0;
    chk("ovf_done", bus.done, 1);
    chk("ovf_err", bus.err, 1);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_we", bus.mem_we, 0);
    chk("ovf_top", bus.top, 512);
    tick();
    chk("ovf_done_off", bus.done, 0);
    chk("ovf_no_write", we_cnt, we0);
    chk("ovf_pop_data", bus.pop_data, 32'hDEADBEEF);
    chk("ovf_sticky", bus.overflow, 1);

    for (int i = 0; i < 212; i++) pop_q();
    chk("drain_top", bus.top, 300);
    chk("drain_pop_data", bus.pop_data, 44);

    // Simultaneous requests: push wins, pop is dropped.
    re0 = re_cnt;
    bus.push_req = 1'b1; bus.pop_req = 1'b1; bus.push_data = 32'hA5A5A5A5;
    tick();
    bus.push_req = 1'b0; bus.pop_req = 1'b0;
    chk("both_we", bus.mem_we, 1);
    chk("both_re", bus.mem_re, 0);
    chk("both_addr", bus.mem_addr, 300);
    chk("both_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    tick();
    chk("both_done", bus.done, 1);
    chk("both_top", bus.top, 301);
    tick();
    chk("both_idle", bus.busy, 0);
    chk("both_mem", mem[300], 32'hA5A5A5A5);
    chk("both_no_read", re_cnt, re0);
    chk("both_pop_data", bus.pop_data, 44);

    // Reset while in POP_WAIT abandons the pop.
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    chk("rpop_re", bus.mem_re, 1);
    chk("rpop_addr", bus.mem_addr, 300);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rpop_done", bus.done, 0);
    chk("rpop_busy", bus.busy, 0);
    chk("rpop_top", bus.top, 256);
    chk("rpop_pop_data", bus.pop_data, 0);
    chk("rpop_ovf", bus.overflow, 0);
    chk("rpop_addr0", bus.mem_addr, 0);
    tick();
    chk("rpop_no_done", bus.done, 0);
    chk("rpop_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
